// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and pipeline-control unit for the 5-stage RV32 pipeline. It watches
// the register-index and write-enable taps of the datapath and returns the
// stall, flush and forwarding selects the datapath consumes. It also runs a
// small handshake FSM for multi-cycle data-memory accesses, with a watchdog
// that gives up on an unanswered request, and keeps two saturating
// performance counters.
//
// Parameters
//   MEM_TIMEOUT  WAIT-state cycles allowed before the watchdog trips (>= 1)
//   CNT_W        width of the performance counters
//
// Ports
//   clk, rst_n                 pipeline clock, asynchronous active-low reset
//   Rs1D, Rs2D                 source registers of the instruction in Decode
//   Rs1E, Rs2E, RdE            sources / destination in Execute
//   RdM, RdW                   destinations in Memory / Writeback
//   RegWriteM, RegWriteW       register write enables in M / W
//   ResultSrcE0                instruction in E is a load
//   PCSrcE                     branch / jump taken in E
//   MemReqM, MemReadyM         data-memory request in M and its completion
//   StallF/D/E/M               hold the F/D/E/M pipeline registers
//   FlushD/E/W                 insert a bubble into the D/E/W pipeline regs
//   ForwardAE, ForwardBE       ALU operand select: 00 RF, 01 ResultW,
//                              10 ALUResultM
//   MemTimeout                 sticky watchdog error flag
//   StallCycles, FlushEvents   saturating performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,

    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushEvents
);

    // Wide enough to hold the value MEM_TIMEOUT itself.
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    state_t         state;
    state_t         stateNext;
    logic [WCW-1:0] waitCnt;
    logic [WCW-1:0] waitCntNext;
    logic           timeoutNext;

    logic           lwStall;
    logic           memStall;

    // -------------------------------------------------------------------------
    // Forwarding select for one ALU operand. The Memory stage holds the younger
    // result, so it wins over Writeback. x0 is hard-wired zero and must never
    // be forwarded, hence the Rd != 0 qualifiers.
    // -------------------------------------------------------------------------
    function automatic logic [1:0] fwdSel(
        input logic [4:0] rs,
        input logic       regWriteM,
        input logic [4:0] rdM,
        input logic       regWriteW,
        input logic [4:0] rdW
    );
        if (regWriteM && (rdM != 5'd0) && (rdM == rs)) begin
            return FWD_MEM;
        end else if (regWriteW && (rdW != 5'd0) && (rdW == rs)) begin
            return FWD_WB;
        end else begin
            return FWD_RF;
        end
    endfunction

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    // A load in E whose destination is read by the instruction in D: the value
    // is not available until after M, so D must wait one cycle.
    assign lwStall = ResultSrcE0 && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

    // Once the watchdog has tripped the memory is considered dead, so the
    // pipeline is released rather than frozen forever.
    assign memStall = MemReqM && !MemReadyM && (state != S_ERR);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_n) begin
            state      <= S_IDLE;
            waitCnt    <= '0;
            MemTimeout <= 1'b0;
        end else begin
            state      <= stateNext;
            waitCnt    <= waitCntNext;
            MemTimeout <= timeoutNext;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    //
    // WaitCnt counts WAIT cycles already spent. The first stalled cycle is
    // spent in IDLE, so a request that is never answered stalls for
    // MEM_TIMEOUT+1 cycles: one in IDLE plus MEM_TIMEOUT in WAIT.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case statement can leave it unassigned and infer a latch.
        stateNext   = state;
        waitCntNext = waitCnt;
        timeoutNext = MemTimeout;

        case (state)
            S_IDLE: begin
                if (memStall) begin
                    stateNext   = S_WAIT;
                    waitCntNext = WCW'(1);
                end
            end

            S_WAIT: begin
                if (MemReadyM || !MemReqM) begin
                    stateNext   = S_IDLE;
                    waitCntNext = '0;
                end else if (waitCnt == WCW'(MEM_TIMEOUT)) begin
                    stateNext   = S_ERR;
                    timeoutNext = 1'b1;
                end else begin
                    waitCntNext = waitCnt + WCW'(1);
                end
            end

            // Terminal until reset; the sticky flag tells software why.
            S_ERR: begin
                stateNext = S_ERR;
            end

            default: begin
                stateNext   = S_IDLE;
                waitCntNext = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM / control outputs
    //
    // The outputs are combinational, but while rst_n is low they must show
    // their reset values immediately (stalls off, D/E/W flushed, no
    // forwarding) without waiting for a clock edge, so rst_n gates them here.
    //
    // memStall dominates: when M is frozen, E is frozen too, so a taken branch
    // sitting in E must not flush yet; it flushes on the release cycle. W gets
    // a bubble because the frozen M instruction has not produced its result.
    // -------------------------------------------------------------------------
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushW    = 1'b1;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;

        if (rst_n) begin
            StallF    = lwStall || memStall;
            StallD    = lwStall || memStall;
            StallE    = memStall;
            StallM    = memStall;
            FlushD    = PCSrcE && !memStall;
            FlushE    = (lwStall || PCSrcE) && !memStall;
            FlushW    = memStall;
            ForwardAE = fwdSel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
            ForwardBE = fwdSel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
        end
    end

    // -------------------------------------------------------------------------
    // Performance counters: cycles with a front-end stall, and cycles in which
    // a bubble enters E. Both stick at all-ones instead of wrapping, so a
    // saturated value reads as "at least this many".
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCycles <= '0;
            FlushEvents <= '0;
        end else begin
            if (StallF && (StallCycles != '1)) begin
                StallCycles <= StallCycles + CNT_W'(1);
            end
            if (FlushE && (FlushEvents != '1)) begin
                FlushEvents <= FlushEvents + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl. The stimulus process drives one vector per
// clock cycle (just after the rising edge) and pushes the hand-computed
// expected outputs into a scoreboard queue. A separate monitor pops one entry
// per falling edge and compares it with what the DUT presents. Counters are
// kept narrow (CNT_W = 4) so saturation is reached quickly, and the watchdog
// is set to MEM_TIMEOUT = 4.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    logic             clk;
    logic             rst_n;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             RegWriteM, RegWriteW, ResultSrcE0, PCSrcE;
    logic             MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             MemTimeout;
    logic [CNT_W-1:0] StallCycles, FlushEvents;

    hazard_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .ResultSrcE0(ResultSrcE0),
        .PCSrcE     (PCSrcE),
        .MemReqM    (MemReqM),
        .MemReadyM  (MemReadyM),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushW     (FlushW),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .MemTimeout (MemTimeout),
        .StallCycles(StallCycles),
        .FlushEvents(FlushEvents)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected response for one cycle.
    typedef struct {
        string            name;
        logic [3:0]       st;   // {StallF, StallD, StallE, StallM}
        logic [2:0]       fl;   // {FlushD, FlushE, FlushW}
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             to;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fe;
    } exp_t;

    exp_t             sbq[$];
    exp_t             monE;
    int               nChecks = 0;
    int               nFails  = 0;
    logic [CNT_W-1:0] mSc = '0;   // expected StallCycles
    logic [CNT_W-1:0] mFe = '0;   // expected FlushEvents

    task automatic check(input string nm, input string field,
                         input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s.%s: got %0h, expected %0h (t=%0t)",
                     nm, field, act, req, $time);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            monE = sbq.pop_front();
            check(monE.name, "stall", {StallF, StallD, StallE, StallM}, monE.st);
            check(monE.name, "flush", {FlushD, FlushE, FlushW}, monE.fl);
            check(monE.name, "fwdA", ForwardAE, monE.fa);
            check(monE.name, "fwdB", ForwardBE, monE.fb);
            check(monE.name, "timeout", MemTimeout, monE.to);
            check(monE.name, "stallCycles", StallCycles, monE.sc);
            check(monE.name, "flushEvents", FlushEvents, monE.fe);
        end
    end

    // Queue the expected outputs for the current cycle, then advance one
    // clock. The counter expectation follows from the expected StallF/FlushE
    // of each cycle, saturating at all-ones and held at zero in reset.
    task automatic pushExp(input string nm, input logic [3:0] st,
                           input logic [2:0] fl, input logic [1:0] fa,
                           input logic [1:0] fb, input logic to);
        exp_t e;
        if (!rst_n) begin
            mSc = '0;
            mFe = '0;
        end
        e.name = nm;
        e.st   = st;
        e.fl   = fl;
        e.fa   = fa;
        e.fb   = fb;
        e.to   = to;
        e.sc   = mSc;
        e.fe   = mFe;
        sbq.push_back(e);
        @(posedge clk);
        if (rst_n) begin
            if (st[3] && (mSc != '1)) mSc = mSc + 1'b1;
            if (fl[1] && (mFe != '1)) mFe = mFe + 1'b1;
        end
        #1;
    endtask

    task automatic clrIn();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE  = 5'd0; RdM  = 5'd0; RdW  = 5'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0;
        PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clrIn();
        @(posedge clk);
        #1;

        // Reset state.
        pushExp("reset", 4'b0000, 3'b111, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;

        // 1. Forwarding priority.
        RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5;
        Rs1E = 5'd5; Rs2E = 5'd5;
        pushExp("fwd_m_prio", 4'b0000, 3'b000, 2'b10, 2'b10, 1'b0);
        RegWriteM = 1'b0;
        pushExp("fwd_w_only", 4'b0000, 3'b000, 2'b01, 2'b01, 1'b0);
        RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        pushExp("fwd_x0", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        RdM = 5'd5; RdW = 5'd6; Rs1E = 5'd5; Rs2E = 5'd6;
        pushExp("fwd_split", 4'b0000, 3'b000, 2'b10, 2'b01, 1'b0);

        // 2. Load-use.
        clrIn();
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        pushExp("lw_rs2", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
        RdE = 5'd0; Rs2D = 5'd0;
        pushExp("lw_x0", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        RdE = 5'd7; Rs1D = 5'd7;
        pushExp("lw_rs1", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);

        // 3. Taken branch, alone and together with a load-use stall.
        clrIn();
        PCSrcE = 1'b1;
        pushExp("branch", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);
        ResultSrcE0 = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
        pushExp("branch_lw", 4'b1100, 3'b110, 2'b00, 2'b00, 1'b0);

        // 4. Memory wait of 3 cycles with a branch frozen in E.
        clrIn();
        MemReqM = 1'b1; PCSrcE = 1'b1;
        repeat (3) pushExp("mem_wait", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        MemReadyM = 1'b1;
        pushExp("mem_release", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);
        clrIn();
        pushExp("mem_idle", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        // Counter saturation: enough load-use cycles to pass all-ones.
        ResultSrcE0 = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
        repeat (16) pushExp("lw_sat", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
        clrIn();
        pushExp("sat_hold", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        // 6. Reset in the middle of WAIT (WaitCnt = 2), with live hazards.
        MemReqM = 1'b1;
        repeat (2) pushExp("miss_pre_rst", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5; PCSrcE = 1'b1;
        ResultSrcE0 = 1'b1; RdE = 5'd8; Rs1D = 5'd8;
        rst_n = 1'b0;
        pushExp("rst_async", 4'b0000, 3'b111, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;

        // 5. Watchdog: a fresh miss stalls exactly MEM_TIMEOUT+1 cycles.
        clrIn();
        MemReqM = 1'b1;
        repeat (MEM_TIMEOUT + 1)
            pushExp("wdog_stall", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        pushExp("wdog_trip", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b1);
        pushExp("err_hold", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b1);
        ResultSrcE0 = 1'b1; RdE = 5'd4; Rs2D = 5'd4;
        RegWriteW = 1'b1; RdW = 5'd2; Rs1E = 5'd2;
        pushExp("err_lwstall", 4'b1100, 3'b010, 2'b01, 2'b00, 1'b1);
        ResultSrcE0 = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b1;
        pushExp("err_branch", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b1);
        clrIn();

        // Let the monitor drain the scoreboard, but never wait forever.
        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            nChecks++;
            nFails++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
